// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: RV32M op codes, FSM state encoding and iteration count shared by the MDU
package mdu_seq_pkg;
  localparam int MDU_XLEN = 32;
  localparam int MDU_N_ITER = 32;
  localparam logic [2:0] MDU_OP_MUL = 3'd0;
  localparam logic [2:0] MDU_OP_MULH = 3'd1;
  localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
  localparam logic [2:0] MDU_OP_MULHU = 3'd3;
  localparam logic [2:0] MDU_OP_DIV = 3'd4;
  localparam logic [2:0] MDU_OP_DIVU = 3'd5;
  localparam logic [2:0] MDU_OP_REM = 3'd6;
  localparam logic [2:0] MDU_OP_REMU = 3'd7;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_t;
endpackage

// File: rtl/mdu_sign.sv
// mdu_sign: operand magnitudes/signs at start and sign fix-up plus result select at completion
module mdu_sign import mdu_seq_pkg::*; (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  input  logic        sa,
  input  logic        sb,
  input  logic [63:0] acc,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  output logic        a_neg,
  output logic        b_neg,
  output logic [31:0] res
);
  logic [63:0] prod;
  logic [31:0] quo, rem;
  always_comb begin
    a_neg = a[31] && (op == MDU_OP_MULH || op == MDU_OP_MULHSU || op == MDU_OP_DIV || op == MDU_OP_REM);
    b_neg = b[31] && (op == MDU_OP_MULH || op == MDU_OP_DIV || op == MDU_OP_REM);
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    prod = (sa ^ sb) ? -acc : acc;
    quo = (sa ^ sb) ? -acc[31:0] : acc[31:0];
    rem = sa ? -acc[63:32] : acc[63:32];
    res = sel == MDU_OP_MUL ? prod[31:0] : !sel[2] ? prod[63:32] : sel[1] ? rem : quo;
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential RV32M multiply/divide unit using shift-add and restoring division
module mdu_seq import mdu_seq_pkg::*; #(
  parameter int XLEN = MDU_XLEN,
  parameter int N_ITER = MDU_N_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mdu_op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] C
);
  mdu_state_t state, nxt;
  logic [5:0] cnt;
  logic [2:0] op_q;
  logic sa, sb, a_neg, b_neg, div0, ovf, go;
  logic [XLEN-1:0] bm, a_mag, b_mag, res, spec;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN:0] sum, diff;
  mdu_sign u_sign (
    .op(mdu_op), .a(A), .b(B), .sel(op_q), .sa(sa), .sb(sb), .acc(acc_nxt),
    .a_mag(a_mag), .b_mag(b_mag), .a_neg(a_neg), .b_neg(b_neg), .res(res)
  );
  always_comb begin
    go = state == IDLE && start && !flush;
    div0 = mdu_op[2] && B == '0;
    ovf = (mdu_op == MDU_OP_DIV || mdu_op == MDU_OP_REM) && A == {1'b1, {(XLEN-1){1'b0}}} && B == '1;
    spec = mdu_op[1] ? (div0 ? A : '0) : (div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, bm} : '0);
    diff = acc[2*XLEN-1:XLEN-1] - {1'b0, bm};
    acc_nxt = !op_q[2] ? {sum, acc[XLEN-1:1]} :
              diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    nxt = flush ? IDLE :
          state == IDLE ? (go ? ((div0 || ovf) ? DONE : CALC) : IDLE) :
          state == CALC ? (cnt == 6'(N_ITER - 1) ? DONE : CALC) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
    stall = go || state == CALC;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      acc <= '0;
      bm <= '0;
      C <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        op_q <= mdu_op;
        sa <= a_neg;
        sb <= b_neg;
        cnt <= '0;
        acc <= {{XLEN{1'b0}}, mdu_op[2] ? a_mag : b_mag};
        bm <= mdu_op[2] ? b_mag : a_mag;
        if (div0 || ovf) C <= spec;
      end else if (state == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (nxt == DONE) C <= res;
      end
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: table-driven and corner-sequence self-checking bench for mdu_seq
module tb_mdu_seq;
  import mdu_seq_pkg::*;
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0] mdu_op = '0;
  logic [31:0] A = '0, B = '0;
  logic busy, stall, done;
  logic [31:0] C;
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b, c;
    int lat;
  } vec_t;
  localparam int N = 18;
  vec_t v[N];
  always #5 clk = ~clk;
  mdu_seq dut (
    .clk(clk), .rst(rst), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .C(C)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic wait_done(input int inj, output int lat, output int nst);
    lat = 0;
    nst = 0;
    @(negedge clk);
    if (stall) nst++;
    @(posedge clk);
    #1 start = 0;
    A = $urandom;
    B = $urandom;
    lat = 1;
    @(negedge clk);
    while (!done && lat < 100) begin
      if (stall) nst++;
      @(posedge clk);
      #1 lat++;
      if (lat == inj) begin
        start = 1;
        mdu_op = MDU_OP_MUL;
        A = 32'd2;
        B = 32'd2;
      end else start = 0;
      @(negedge clk);
    end
  endtask
  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input int elat, input int inj);
    int lat, nst;
    mdu_op = op;
    A = a;
    B = b;
    start = 1;
    wait_done(inj, lat, nst);
    chk({name, " C"}, C, c);
    chk({name, " latency"}, lat, elat);
    chk({name, " stall cycles"}, nst, elat);
    chk({name, " stall in done"}, {31'd0, stall}, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    v[0]  = '{MDU_OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    v[1]  = '{MDU_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    v[2]  = '{MDU_OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    v[3]  = '{MDU_OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    v[4]  = '{MDU_OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    v[5]  = '{MDU_OP_DIVU,   32'd12345,    32'd0,        32'hFFFFFFFF, 1};
    v[6]  = '{MDU_OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    v[7]  = '{MDU_OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    v[8]  = '{MDU_OP_REMU,   32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1};
    v[9]  = '{MDU_OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    v[10] = '{MDU_OP_DIVU,   32'd100,      32'd7,        32'd14,       33};
    v[11] = '{MDU_OP_REMU,   32'd100,      32'd7,        32'd2,        33};
    v[12] = '{MDU_OP_MUL,    32'h12345678, 32'd9,        32'hA3D70A38, 33};
    v[13] = '{MDU_OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
    v[14] = '{MDU_OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    v[15] = '{MDU_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
    v[16] = '{MDU_OP_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, 33};
    v[17] = '{MDU_OP_DIV,    32'h80000000, 32'd2,        32'hC0000000, 33};
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset stall", {31'd0, stall}, 0);
    chk("reset C", C, 0);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < N; i++) run($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].c, v[i].lat, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("C hold", C, v[N-1].c);
    mdu_op = MDU_OP_MUL;
    A = 32'd3;
    B = 32'd5;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("flush busy", {31'd0, busy}, 0);
    chk("flush done", {31'd0, done}, 0);
    chk("flush C", C, v[N-1].c);
    @(posedge clk);
    #1;
    chk("flush C later", C, v[N-1].c);
    run("after flush", MDU_OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, -1);
    run("start while busy", MDU_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 5);
    run("back to back", MDU_OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 33, -1);
    mdu_op = MDU_OP_MUL;
    A = 32'd3;
    B = 32'd5;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    #1 rst = 1;
    start = 1;
    A = 32'd9;
    B = 32'd9;
    @(posedge clk);
    #1 rst = 0;
    start = 0;
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst done", {31'd0, done}, 0);
    chk("rst stall", {31'd0, stall}, 0);
    chk("rst C", C, 0);
    @(posedge clk);
    #1;
    run("after rst", MDU_OP_MUL, 32'd3, 32'd5, 32'd15, 33, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
